// File: rtl/idecode_regfile_pkg.sv
// -----------------------------------------------------------------------------
// idecode_regfile_pkg
// Shared constants for the instruction-decode / register-file slice:
//   - I-type opcodes whose immediate is zero-extended (ANDI, ORI, XORI, SLTIU)
//   - architectural register numbers ($0 and the jal link register $31)
//   - instruction field bit positions (opcode, rs, rt, rd, immediate)
//   - helper that classifies an opcode as zero-extending
// -----------------------------------------------------------------------------
package idecode_regfile_pkg;

    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;
    localparam logic [5:0] SLTIU = 6'h0B;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Logical immediates and sltiu treat the 16-bit field as unsigned.
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == ANDI) || (op == ORI) || (op == XORI) || (op == SLTIU);
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// -----------------------------------------------------------------------------
// regfile_32x32
// 32 x 32-bit register storage: two asynchronous read ports, one write port
// committed on the rising clock edge, and a synchronous clear of every entry.
// $0 always reads zero and is never written.
// Ports:
//   clock          in   rising-edge clock
//   clear          in   synchronous clear of all registers (wins over write)
//   we             in   write enable
//   waddr, wdata   in   write address / data
//   raddr1/raddr2  in   read addresses
//   rdata1/rdata2  out  combinational read data (no write bypass)
// -----------------------------------------------------------------------------
module regfile_32x32
    import idecode_regfile_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (clear) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'h0000_0000;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    // Reads see the stored array only: a write becomes visible after its edge.
    always_comb begin
        rdata1 = (raddr1 == REG_ZERO) ? 32'h0000_0000 : regs_q[raddr1];
        rdata2 = (raddr2 == REG_ZERO) ? 32'h0000_0000 : regs_q[raddr2];
    end

endmodule

// File: rtl/idecode_regfile.sv
// -----------------------------------------------------------------------------
// idecode_regfile
// Instruction-decode stage: register-file reads for rs/rt, write-back
// destination and data selection, and immediate extension.
// Ports:
//   clock        in   rising edge commits register writes
//   reset        in   synchronous active-high; clears registers, drops write
//   instruction  in   current instruction
//   link_addr    in   PC+4, written to $31 on jal
//   alu_result   in   ALU write-back data
//   mem_data     in   memory/IO write-back data
//   jal          in   jal: dest $31, data link_addr (priority over others)
//   reg_write    in   instruction writes a register
//   mem_to_reg   in   write-back source is mem_data
//   reg_dst      in   1 = rd, 0 = rt destination
//   read_data_1  out  value of rs (also jr target)
//   read_data_2  out  value of rt
//   imme_extend  out  zero- or sign-extended 16-bit immediate
// -----------------------------------------------------------------------------
module idecode_regfile
    import idecode_regfile_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] link_addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic        jal,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        reg_dst,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [31:0] imme_extend
);

    logic [5:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm;
    logic [4:0]  dest_addr;
    logic [31:0] wr_data;
    logic        wr_en;

    assign opcode  = instruction[OP_HI:OP_LO];
    assign rs_addr = instruction[RS_HI:RS_LO];
    assign rt_addr = instruction[RT_HI:RT_LO];
    assign rd_addr = instruction[RD_HI:RD_LO];
    assign imm     = instruction[IMM_HI:IMM_LO];

    // jal overrides both reg_dst and mem_to_reg.
    always_comb begin
        dest_addr = rt_addr;
        wr_data   = alu_result;
        if (jal) begin
            dest_addr = REG_RA;
            wr_data   = link_addr;
        end else begin
            if (reg_dst) begin
                dest_addr = rd_addr;
            end
            if (mem_to_reg) begin
                wr_data = mem_data;
            end
        end
    end

    assign wr_en = (reg_write | jal) & ~reset;

    always_comb begin
        if (is_zero_ext_op(opcode)) begin
            imme_extend = {16'h0000, imm};
        end else begin
            imme_extend = {{16{imm[15]}}, imm};
        end
    end

    regfile_32x32 u_regfile (
        .clock  (clock),
        .clear  (reset),
        .we     (wr_en),
        .waddr  (dest_addr),
        .wdata  (wr_data),
        .raddr1 (rs_addr),
        .raddr2 (rt_addr),
        .rdata1 (read_data_1),
        .rdata2 (read_data_2)
    );

endmodule
